// File: rtl/uart_word_assembler_pkg.sv
// Shared UART constants and the word assembler's state type.
package uart_word_assembler_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned OVERSAMPLE        = 16;
  localparam int unsigned NBYTES_DEF        = 4;
  // Ten bit times of idle line at 16x oversampling.
  localparam int unsigned TIMEOUT_TICKS_DEF = 10 * OVERSAMPLE;

  typedef enum logic [0:0] {
    StCollect = 1'b0,
    StHold    = 1'b1
  } state_e;

endpackage

// File: rtl/uart_word_assembler_if.sv
// Receiver-side byte stream plus the consumer-side word handshake and status pulses.
interface uart_word_assembler_if
  import uart_word_assembler_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEF
);

  logic                       rx_done_tick;
  logic [BYTE_W-1:0]          rx_data;
  logic                       word_ready;
  logic                       word_valid;
  logic [BYTE_W*NBYTES-1:0]   word_out;
  logic                       overflow;
  logic                       timeout;

  // The assembler.
  modport master (
    input  rx_done_tick, rx_data, word_ready,
    output word_valid, word_out, overflow, timeout
  );

  // The receiver/consumer environment around the assembler.
  modport slave (
    output rx_done_tick, rx_data, word_ready,
    input  word_valid, word_out, overflow, timeout
  );

endinterface

// File: rtl/uart_word_assembler.sv
// Packs UART bytes into NBYTES-wide words (first byte in the MSBs), holds a finished word
// until the consumer takes it, and discards stale partial words after an idle timeout.
module uart_word_assembler
  import uart_word_assembler_pkg::*;
#(
  parameter int unsigned NBYTES        = NBYTES_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  uart_word_assembler_if.master bus
);

  localparam int unsigned WORD_W = BYTE_W * NBYTES;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [CNT_W-1:0]  LastIdx  = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0]  FullCnt  = CNT_W'(NBYTES);
  localparam logic [IDLE_W-1:0] IdleLast = IDLE_W'(TIMEOUT_TICKS - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                ovf_q, ovf_d;
  logic                tmo_q, tmo_d;
  logic [WORD_W-1:0]   word_shifted;

  assign word_shifted = {word_q[WORD_W-BYTE_W-1:0], bus.rx_data};

  // State, counters, word and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StCollect;
      count_q <= '0;
      idle_q  <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idle_q  <= idle_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state: byte accumulation, hold/handshake, overflow and idle timeout.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idle_d  = idle_q;
    word_d  = word_q;
    ovf_d   = 1'b0;
    tmo_d   = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (bus.rx_done_tick) begin
          // A byte always beats a coincident timeout expiry.
          word_d = word_shifted;
          idle_d = '0;
          if (count_q == LastIdx) begin
            state_d = StHold;
            count_d = FullCnt;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else if (count_q != '0 && baud_tick) begin
          if (idle_q == IdleLast) begin
            count_d = '0;
            idle_d  = '0;
            tmo_d   = 1'b1;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end

      StHold: begin
        idle_d = '0;
        if (bus.word_ready) begin
          state_d = StCollect;
          count_d = '0;
          // A byte arriving on the handshake cycle starts the next word.
          if (bus.rx_done_tick) begin
            word_d  = word_shifted;
            count_d = CNT_W'(1);
          end
        end else if (bus.rx_done_tick) begin
          ovf_d = 1'b1;
        end
      end

      default: begin
        state_d = StCollect;
      end
    endcase
  end

  assign bus.word_valid = (state_q == StHold);
  assign bus.word_out   = word_q;
  assign bus.overflow   = ovf_q;
  assign bus.timeout    = tmo_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler (NBYTES=4, TIMEOUT_TICKS=160) with a word scoreboard.
module tb_uart_word_assembler;

  localparam int unsigned NB = 4;
  localparam int unsigned TT = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud_tick = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int ovf_cnt = 0;
  int tmo_cnt = 0;
  logic [8*NB-1:0] exp_q[$];

  uart_word_assembler_if #(.NBYTES(NB)) bus ();

  uart_word_assembler #(
    .NBYTES       (NB),
    .TIMEOUT_TICKS(TT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handshaken word is compared with the oldest expected one.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.overflow) ovf_cnt++;
      if (bus.timeout)  tmo_cnt++;
      if (bus.word_valid && bus.word_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $error("FAIL sb_unexpected: observed word %0h, required no word", bus.word_out);
        end else begin
          automatic logic [8*NB-1:0] e = exp_q.pop_front();
          assert (bus.word_out === e) else begin
            n_bad++;
            $error("FAIL sb_word: observed %0h required %0h", bus.word_out, e);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.rx_data      = b;
    tick();
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
  endtask

  task automatic baud(input int n);
    baud_tick = 1'b1;
    repeat (n) tick();
    baud_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(bus.word_valid), 64'd0);
    check({tag, "_word"},  64'(bus.word_out),   64'd0);
    check({tag, "_ovf"},   64'(bus.overflow),   64'd0);
    check({tag, "_tmo"},   64'(bus.timeout),    64'd0);
  endtask

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.word_ready   = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Basic word, consumer ready: valid one cycle after the 4th byte, handshake that cycle
    bus.word_ready = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    send(8'hDE); send(8'hAD); send(8'hBE);
    check("pre_valid", 64'(bus.word_valid), 64'd0);
    send(8'hEF);
    check("valid_rise", 64'(bus.word_valid), 64'd1);
    check("word_deadbeef", 64'(bus.word_out), 64'hDEADBEEF);
    tick();
    check("valid_fall", 64'(bus.word_valid), 64'd0);
    check("sb_drained1", 64'(exp_q.size()), 64'd0);

    // Overflow while holding
    bus.word_ready = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h55);
    check("ovf_pulse", 64'(bus.overflow), 64'd1);
    tick();
    check("ovf_one_cycle", 64'(bus.overflow), 64'd0);
    check("ovf_word_kept", 64'(bus.word_out), 64'hDEADBEEF);
    check("ovf_valid_kept", 64'(bus.word_valid), 64'd1);
    bus.word_ready = 1'b1;
    tick();
    check("sb_drained2", 64'(exp_q.size()), 64'd0);
    check("ovf_count", 64'(ovf_cnt), 64'd1);

    // Timeout after 160 idle baud ticks with 2 bytes pending
    send(8'hAA); send(8'hBB);
    baud(TT - 1);
    check("tmo_early", 64'(tmo_cnt), 64'd0);
    baud(1);
    check("tmo_pulse", 64'(bus.timeout), 64'd1);
    tick();
    check("tmo_one_cycle", 64'(bus.timeout), 64'd0);
    check("tmo_count", 64'(tmo_cnt), 64'd1);
    exp_q.push_back(32'h01020304);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    check("post_tmo_valid", 64'(bus.word_valid), 64'd1);
    check("post_tmo_word", 64'(bus.word_out), 64'h01020304);
    tick();

    // Byte coincident with tick 160: accepted, no timeout, count becomes 3
    send(8'hA1); send(8'hA2);
    baud(TT - 1);
    baud_tick = 1'b1;
    send(8'hA3);
    baud_tick = 1'b0;
    check("race_no_tmo", 64'(bus.timeout), 64'd0);
    check("race_valid_low", 64'(bus.word_valid), 64'd0);
    exp_q.push_back(32'hA1A2A3A4);
    send(8'hA4);
    check("race_valid", 64'(bus.word_valid), 64'd1);
    check("race_word", 64'(bus.word_out), 64'hA1A2A3A4);
    tick();
    check("race_tmo_count", 64'(tmo_cnt), 64'd1);

    // Handshake with coincident byte starts the next word
    bus.word_ready = 1'b0;
    exp_q.push_back(32'h55667788);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    exp_q.push_back(32'h11223344);
    bus.word_ready = 1'b1;
    send(8'h11);
    check("hs_byte_no_ovf", 64'(bus.overflow), 64'd0);
    check("hs_byte_collect", 64'(bus.word_valid), 64'd0);
    send(8'h22); send(8'h33);
    check("hs_byte_3of4", 64'(bus.word_valid), 64'd0);
    send(8'h44);
    check("hs_next_word", 64'(bus.word_out), 64'h11223344);
    tick();
    check("sb_drained3", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-word
    send(8'h91); send(8'h92); send(8'h93);
    #3 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    tick();
    rst = 1'b1;
    tick();

    // Asynchronous reset in HOLD (word never handed over, so not expected)
    bus.word_ready = 1'b0;
    send(8'hB1); send(8'hB2); send(8'hB3); send(8'hB4);
    check("hold_before_rst", 64'(bus.word_valid), 64'd1);
    #3 rst = 1'b0;
    #1 check_all_zero("rst_hold");
    tick();
    rst = 1'b1;
    tick();
    check("rst_no_pulses", 64'(ovf_cnt + tmo_cnt), 64'd2);

    bus.word_ready = 1'b1;
    exp_q.push_back(32'hCAFEF00D);
    send(8'hCA); send(8'hFE); send(8'hF0); send(8'h0D);
    check("post_rst_word", 64'(bus.word_out), 64'hCAFEF00D);
    tick();
    tick();
    check("sb_final_empty", 64'(exp_q.size()), 64'd0);
    check("final_ovf_count", 64'(ovf_cnt), 64'd1);
    check("final_tmo_count", 64'(tmo_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 SHALL have parameter NBYTES, default 4: bytes per assembled word (legal 2..16).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 160: inter-byte timeout in baud_tick pulses (10 bit times at 16x oversampling; legal 2..4095).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port baud_tick  input  1  16x-oversampling tick, one clk wide, from the shared baud generator.
REQ-006 SHALL have port rx_done_tick  input  1  one-cycle pulse from the UART receiver: byte complete.
REQ-007 SHALL have port rx_data  input  8  received byte, valid in the rx_done_tick cycle.
REQ-008 SHALL have port word_ready  input  1  consumer accepts word_out.
REQ-009 SHALL have port word_valid  output  1  word_out holds a complete word.
REQ-010 SHALL have port word_out  output  8*NBYTES  assembled word; first received byte in MSB position.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse: byte dropped.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse: partial word discarded.

Function
REQ-013 SHALL implement a two-state FSM: COLLECT (word_valid=0) and HOLD (word_valid=1).
REQ-014 In COLLECT, on rx_done_tick, SHALL shift: word = {word[8*NBYTES-9:0], rx_data}; byte_count increments.
REQ-015 When the byte arriving in COLLECT is byte NBYTES, SHALL enter HOLD; word_valid rises the clk after that rx_done_tick (latency 1 cycle).
REQ-016 In HOLD, word_out and word_valid SHALL remain stable until word_valid&&word_ready; that cycle returns to COLLECT with byte_count=0.
REQ-017 word_ready while in COLLECT SHALL have no effect.
REQ-018 rx_done_tick in HOLD without handshake in the same cycle SHALL drop the byte, leave word_out unchanged, and pulse overflow for one cycle.
REQ-019 rx_done_tick in the same cycle as the HOLD handshake SHALL be accepted as byte 1 of the next word (byte_count=1, no overflow).
REQ-020 In COLLECT with byte_count>0, SHALL count baud_tick pulses in an idle counter; rx_done_tick clears it to 0.
REQ-021 When the idle counter reaches TIMEOUT_TICKS, SHALL clear byte_count and the idle counter, pulse timeout for one cycle, and stay in COLLECT; word_out contents are don't-care.
REQ-022 rx_done_tick coincident with timeout expiry SHALL win: byte accepted, idle counter cleared, no timeout pulse.
REQ-023 Idle counter SHALL hold at 0 while byte_count==0 and while in HOLD.
REQ-024 byte_count width SHALL be clog2(NBYTES+1); idle counter width clog2(TIMEOUT_TICKS+1); no wrap-around is reachable.

Reset
REQ-025 rst low SHALL immediately force COLLECT, byte_count=0, idle counter=0, word_out=0, word_valid=0, overflow=0, timeout=0.
REQ-026 Reset mid-word or in HOLD SHALL discard all partial/held data with no pulse on overflow or timeout.
REQ-027 First byte accepted SHALL be the first rx_done_tick sampled at a rising clk after rst deasserts.

Structure
REQ-028 Byte width (8), default NBYTES and default TIMEOUT_TICKS SHALL live in the shared UART constants package/include, alongside the baud oversampling factor 16.
REQ-029 SHALL be a single module, no sub-modules; FSM split into registered state and combinational next-state logic.

Verification
REQ-030 NBYTES=4: bytes 0xDE,0xAD,0xBE,0xEF, word_ready=1 -> word_valid one cycle after 4th tick, word_out=0xDEADBEEF, handshake that cycle.
REQ-031 word_ready=0, word complete, extra byte 0x55 -> overflow pulses once, word_out stays 0xDEADBEEF, word_valid stays 1.
REQ-032 Two bytes then 160 baud_ticks idle -> timeout pulses once at tick 160; next 4 bytes 0x01..0x04 -> word_out=0x01020304.
REQ-033 Byte on the same cycle as tick 160 -> no timeout, byte_count=3.
REQ-034 HOLD handshake with coincident byte 0x11 -> no overflow; after 3 more bytes 0x22,0x33,0x44 word_out=0x11223344.
REQ-035 rst pulsed low asynchronously after 3 bytes and in HOLD -> all outputs 0 immediately; next full word assembles correctly.
